// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings and FSM states.
package dm_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_WD   = 3'd1,
    OP_HF   = 3'd2,
    OP_BT   = 3'd3,
    OP_UHF  = 3'd4,
    OP_UBT  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  // Encodings 6 and 7 are unused; unsigned sizes have no store form.
  function automatic logic op_illegal(input logic [2:0] op, input logic we);
    return (op > 3'd5) || (we && (op == OP_UHF || op == OP_UBT));
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lane);
    return ((op == OP_WD) && (lane != 2'b00)) ||
           ((op == OP_HF || op == OP_UHF) && lane[0]);
  endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// Request/response/write-log bundle between a requester and dm_ctrl.
interface dm_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        wlog_valid;
  logic [31:0] wlog_pc;
  logic [31:0] wlog_addr;
  logic [31:0] wlog_data;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           wlog_valid, wlog_pc, wlog_addr, wlog_data
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           wlog_valid, wlog_pc, wlog_addr, wlog_data
  );
endinterface

// File: rtl/dm_lane.sv
// Byte-lane extract (loads) and merge (stores) for one 32-bit little-endian word.
module dm_lane
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [15:0] hsel;
  logic [7:0]  bsel;

  always_comb begin
    hsel   = lane[1] ? word[31:16] : word[15:0];
    bsel   = word[{lane, 3'b000} +: 8];
    rdata  = '0;
    merged = word;
    case (op_e'(op))
      OP_WD: begin
        rdata  = word;
        merged = wdata;
      end
      OP_HF: begin
        rdata = {{16{hsel[15]}}, hsel};
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      OP_BT: begin
        rdata = {{24{bsel[7]}}, bsel};
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      OP_UHF: rdata = {16'h0000, hsel};
      OP_UBT: rdata = {24'h000000, bsel};
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: zeroes the array after reset, then serves one load/store
// per LATENCY cycles and logs every committed store.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input logic       clk,
  input logic       rst,
  dm_ctrl_if.slave  bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

  state_e        state, state_nx;
  logic [AW-1:0] clr_cnt;
  logic [3:0]    cnt;
  logic          ready, accept;

  logic          r_we;
  logic [2:0]    r_op;
  logic [31:0]   r_addr, r_wdata, r_pc;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   word, lane_rdata, merged;
  logic          in_range, err, load_ok, commit;

  assign idx      = r_addr[AW+1:2];
  assign word     = mem[idx];
  assign in_range = r_addr[31:2] < 30'(DEPTH);
  assign err      = (r_op != OP_NONE) &&
                    (op_illegal(r_op, r_we) || op_misaligned(r_op, r_addr[1:0]) || !in_range);
  assign load_ok  = (state == S_RESP) && !r_we && (r_op != OP_NONE) && !err;
  assign commit   = (state == S_RESP) &&  r_we && (r_op != OP_NONE) && !err;

  dm_lane u_lane (
    .op     (r_op),
    .lane   (r_addr[1:0]),
    .word   (word),
    .wdata  (r_wdata),
    .rdata  (lane_rdata),
    .merged (merged)
  );

  // An accept in RESP overrides the return to IDLE, giving back-to-back throughput.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      S_CLEAR: if (clr_cnt == AW'(DEPTH - 1)) state_nx = S_IDLE;
      S_IDLE:  ready = 1'b1;
      S_WAIT:  if (cnt == 4'd0) state_nx = S_RESP;
      S_RESP: begin
        ready    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_CLEAR;
    endcase
    accept = ready && bus.req_valid;
    if (accept) state_nx = (LATENCY > 1) ? S_WAIT : S_RESP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      cnt     <= '0;
      r_we    <= 1'b0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept) begin
        cnt     <= WAIT_LOAD;
        r_we    <= bus.req_we;
        r_op    <= bus.req_op;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_pc    <= bus.req_pc;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // The array itself has no reset; it is zeroed only by the CLEAR sweep.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) mem[clr_cnt] <= '0;
    else if (commit)      mem[idx]     <= merged;
  end

  assign bus.req_ready  = ready;
  assign bus.busy       = (state == S_CLEAR);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_err   = (state == S_RESP) && err;
  assign bus.resp_rdata = load_ok ? lane_rdata : 32'h0;
  assign bus.wlog_valid = commit;
  assign bus.wlog_pc    = commit ? r_pc : 32'h0;
  assign bus.wlog_addr  = commit ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.wlog_data  = commit ? merged : 32'h0;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl (DEPTH=16, LATENCY=2): directed vector table,
// multi-cycle corner sequences and randomized accesses against a word-array model.
module tb_dm_ctrl;
  import dm_pkg::*;

  localparam int DEPTH   = 16;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dm_ctrl_if bus ();

  dm_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        wv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] wp;
    int          lat;
  } resp_t;

  typedef struct {
    bit        we;
    bit [2:0]  op;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp_rdata;
    bit        exp_err;
    bit        exp_wlog;
    bit [31:0] exp_wdata;
  } vec_t;

  int        n_checks = 0;
  int        n_pass   = 0;
  bit [31:0] model [DEPTH];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Memory as plain words: sizes in bytes, lanes as shifts and masks.
  function automatic void modelAccess(input bit we, input bit [2:0] op, input bit [31:0] addr,
                                      input bit [31:0] wdata, output bit [31:0] rdata,
                                      output bit err, output bit wlog, output bit [31:0] wword);
    int        idx, off, size;
    bit [31:0] mask, word, val;
    idx   = int'(addr >> 2);
    off   = int'(addr % 4);
    size  = (op == 1) ? 4 : ((op == 2 || op == 4) ? 2 : 1);
    err   = (op != 0) && (op > 5 || (we && op >= 4) || (off % size != 0) || idx >= DEPTH);
    rdata = 0;
    wlog  = 0;
    wword = 0;
    if (op == 0 || err) return;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
    if (we) begin
      word       = (model[idx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      model[idx] = word;
      wlog       = 1;
      wword      = word;
    end else begin
      val = (model[idx] >> (8 * off)) & mask;
      if ((op == 2 || op == 3) && val[8 * size - 1]) val = val | ~mask;
      rdata = val;
    end
  endfunction

  task automatic applyStimulus(input bit we, input bit [2:0] op, input bit [31:0] addr,
                               input bit [31:0] wdata, input bit [31:0] pc, output resp_t r);
    int guard;
    r.rdata = 0; r.err = 0; r.wv = 0; r.wa = 0; r.wd = 0; r.wp = 0; r.lat = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_pc    = pc;
    guard = 0;
    while (!bus.req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_op    = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_pc    = $urandom;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        r.rdata = bus.resp_rdata;
        r.err   = bus.resp_err;
        r.wv    = bus.wlog_valid;
        r.wa    = bus.wlog_addr;
        r.wd    = bus.wlog_data;
        r.wp    = bus.wlog_pc;
        r.lat   = k;
        break;
      end
    end
  endtask

  task automatic checkResp(input string tag, input resp_t r, input bit [31:0] exp_rdata,
                           input bit exp_err, input bit exp_wlog, input bit [31:0] exp_wdata,
                           input bit [31:0] exp_waddr, input bit [31:0] exp_pc);
    checkOutput({tag, " latency"}, r.lat, LATENCY);
    checkOutput({tag, " rdata"}, r.rdata, exp_rdata);
    checkOutput({tag, " err"}, r.err, exp_err);
    checkOutput({tag, " wlog_valid"}, r.wv, exp_wlog);
    if (exp_wlog) begin
      checkOutput({tag, " wlog_addr"}, r.wa, exp_waddr);
      checkOutput({tag, " wlog_data"}, r.wd, exp_wdata);
      checkOutput({tag, " wlog_pc"}, r.wp, exp_pc);
    end
  endtask

  // Called at the negedge where rst was just released; counts cycles with busy high.
  task automatic waitClear(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, n, DEPTH);
    checkOutput({tag, " ready after clear"}, bus.req_ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t      vecs[$];
    resp_t     r;
    bit [31:0] m_rd, m_wd, pc, addr, wdata;
    bit        m_err, m_wl, we;
    bit [2:0]  op;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_pc    = 32'h0;

    vecs.push_back('{0, 3'd1, 32'h00, 32'h0,         32'h0000_0000, 0, 0, 32'h0});
    vecs.push_back('{1, 3'd1, 32'h08, 32'h1234_5678, 32'h0,         0, 1, 32'h1234_5678});
    vecs.push_back('{0, 3'd3, 32'h0B, 32'h0,         32'h0000_0012, 0, 0, 32'h0});
    vecs.push_back('{0, 3'd5, 32'h08, 32'h0,         32'h0000_0078, 0, 0, 32'h0});
    vecs.push_back('{1, 3'd3, 32'h05, 32'hFFFF_FF80, 32'h0,         0, 1, 32'h0000_8000});
    vecs.push_back('{0, 3'd2, 32'h04, 32'h0,         32'hFFFF_8000, 0, 0, 32'h0});
    vecs.push_back('{0, 3'd4, 32'h04, 32'h0,         32'h0000_8000, 0, 0, 32'h0});
    vecs.push_back('{0, 3'd1, 32'h02, 32'h0,         32'h0,         1, 0, 32'h0});
    vecs.push_back('{1, 3'd2, 32'h03, 32'hAAAA_AAAA, 32'h0,         1, 0, 32'h0});
    vecs.push_back('{1, 3'd5, 32'h00, 32'h0000_00AA, 32'h0,         1, 0, 32'h0});
    vecs.push_back('{0, 3'd1, 32'h40, 32'h0,         32'h0,         1, 0, 32'h0});
    vecs.push_back('{0, 3'd1, 32'h04, 32'h0,         32'h0000_8000, 0, 0, 32'h0});
    vecs.push_back('{0, 3'd1, 32'h08, 32'h0,         32'h1234_5678, 0, 0, 32'h0});
    vecs.push_back('{0, 3'd1, 32'h00, 32'h0,         32'h0000_0000, 0, 0, 32'h0});
    vecs.push_back('{0, 3'd0, 32'h08, 32'h0,         32'h0,         0, 0, 32'h0});
    vecs.push_back('{1, 3'd7, 32'h08, 32'h5555_5555, 32'h0,         1, 0, 32'h0});
    vecs.push_back('{0, 3'd6, 32'h08, 32'h0,         32'h0,         1, 0, 32'h0});
    vecs.push_back('{1, 3'd2, 32'h0E, 32'hABCD_BEEF, 32'h0,         0, 1, 32'hBEEF_0000});
    vecs.push_back('{0, 3'd3, 32'h0F, 32'h0,         32'hFFFF_FFBE, 0, 0, 32'h0});
    vecs.push_back('{0, 3'd2, 32'h0E, 32'h0,         32'hFFFF_BEEF, 0, 0, 32'h0});
    vecs.push_back('{1, 3'd1, 32'h3C, 32'hCAFE_F00D, 32'h0,         0, 1, 32'hCAFE_F00D});
    vecs.push_back('{0, 3'd4, 32'h3E, 32'h0,         32'h0000_CAFE, 0, 0, 32'h0});
    vecs.push_back('{0, 3'd3, 32'h3C, 32'h0,         32'h0000_000D, 0, 0, 32'h0});
    vecs.push_back('{1, 3'd0, 32'h08, 32'h9999_9999, 32'h0,         0, 0, 32'h0});
    vecs.push_back('{0, 3'd1, 32'h08, 32'h0,         32'h1234_5678, 0, 0, 32'h0});

    // Reset held: outputs idle, busy asserted.
    repeat (3) @(negedge clk);
    checkOutput("reset busy", bus.busy, 1'b1);
    checkOutput("reset req_ready", bus.req_ready, 1'b0);
    checkOutput("reset resp_valid", bus.resp_valid, 1'b0);
    checkOutput("reset resp_err", bus.resp_err, 1'b0);
    checkOutput("reset resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset wlog_valid", bus.wlog_valid, 1'b0);
    checkOutput("reset wlog_data", bus.wlog_data, 32'h0);
    rst = 1'b0;
    waitClear("initial");

    $display("[TB] directed vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      pc = 32'h1000 + 32'(4 * i);
      applyStimulus(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, pc, r);
      modelAccess(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_wl, m_wd);
      checkResp($sformatf("vec%0d", i), r, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_wlog,
                vecs[i].exp_wdata, vecs[i].addr & ~32'h3, pc);
    end

    $display("[TB] back-to-back store then load");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_op    = 3'd1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hDEAD_BEEF;
    bus.req_pc    = 32'h2000;
    @(posedge clk);
    #1;
    bus.req_we    = 1'b0;
    bus.req_wdata = 32'h0;
    bus.req_pc    = 32'h2004;
    @(negedge clk);
    checkOutput("b2b store wait resp_valid", bus.resp_valid, 1'b0);
    checkOutput("b2b store wait req_ready", bus.req_ready, 1'b0);
    @(negedge clk);
    checkOutput("b2b store resp_valid", bus.resp_valid, 1'b1);
    checkOutput("b2b store wlog_valid", bus.wlog_valid, 1'b1);
    checkOutput("b2b store wlog_data", bus.wlog_data, 32'hDEAD_BEEF);
    checkOutput("b2b resp req_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b load wait resp_valid", bus.resp_valid, 1'b0);
    @(negedge clk);
    checkOutput("b2b load resp_valid", bus.resp_valid, 1'b1);
    checkOutput("b2b load rdata", bus.resp_rdata, 32'hDEAD_BEEF);
    checkOutput("b2b load wlog_valid", bus.wlog_valid, 1'b0);
    modelAccess(1'b1, 3'd1, 32'h20, 32'hDEAD_BEEF, m_rd, m_err, m_wl, m_wd);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
      addr  = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      wdata = $urandom;
      pc    = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(we, op, addr, wdata, pc, r);
      modelAccess(we, op, addr, wdata, m_rd, m_err, m_wl, m_wd);
      checkResp($sformatf("rand%0d we=%0d op=%0d addr=0x%0h", i, we, op, addr), r,
                m_rd, m_err, m_wl, m_wd, addr & ~32'h3, pc);
    end

    $display("[TB] reset during store wait");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_op    = 3'd1;
    bus.req_addr  = 32'h24;
    bus.req_wdata = 32'h55AA_55AA;
    bus.req_pc    = 32'h3000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort in wait busy", bus.busy, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort resp_valid", bus.resp_valid, 1'b0);
      checkOutput("abort wlog_valid", bus.wlog_valid, 1'b0);
    end
    rst = 1'b0;
    waitClear("after abort");
    applyStimulus(1'b0, 3'd1, 32'h24, 32'h0, 32'h3004, r);
    checkResp("abort load 0x24", r, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 3'd1, 32'h08, 32'h0, 32'h3008, r);
    checkResp("abort load 0x08", r, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 3'd1, 32'h20, 32'h0, 32'h300C, r);
    checkResp("abort load 0x20", r, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
